conclover_sample_ram: RTL and testbench

- Avalon-MM slave responder that answers the conclover memory-access master (16-bit address, 32-bit data).
- Holds the input sample block read by the correlator and receives the result block written back.
- On-chip word memory with pipelined reads of fixed latency, programmable wait-state insertion and outstanding-read throttling, so the master's waitrequest/readdatavalid paths can be exercised under back-pressure.
- Provides sticky error and write-count status for the bench and for software.

---
 rtl/conclover_sample_ram.sv | 194 +++++++++++++++++++
 tb/tb_conclover_sample_ram.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conclover_sample_ram.sv
// conclover_sample_ram
// Avalon-MM slave word memory answering the conclover memory-access master.
// It holds the input sample block read by the correlator and receives the
// result block written back. Reads are pipelined with a fixed latency. The
// slave can insert wait states and limit the number of outstanding reads,
// so the master's waitrequest and readdatavalid handling can be tested under
// back-pressure. Sticky status outputs are provided for the bench and for
// software.
//
// Ports
//   csi_clk               system clock, rising edge
//   rsi_reset_n           asynchronous active-low reset
//   avs_s1_write/read     transfer requests, held by the master while stalled
//   avs_s1_address        word address (16 bit)
//   avs_s1_writedata      write data (32 bit)
//   avs_s1_waitrequest    combinational stall: wait-state term | read throttle
//   avs_s1_readdatavalid  one pulse per accepted read, READ_LAT cycles later
//   avs_s1_readdata       read data, forced to zero when not valid
//   coe_clr               synchronous clear of the status outputs
//   coe_words_written     saturating count of accepted in-range writes
//   coe_err               sticky error: out-of-range access or read+write together

`timescale 1ns/1ps

module conclover_sample_ram #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned READ_LAT    = 2,
    parameter int unsigned MAX_PEND    = 2,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        csi_clk,
    input  logic        rsi_reset_n,
    input  logic        avs_s1_write,
    input  logic        avs_s1_read,
    input  logic [15:0] avs_s1_address,
    input  logic [31:0] avs_s1_writedata,
    output logic        avs_s1_waitrequest,
    output logic        avs_s1_readdatavalid,
    output logic [31:0] avs_s1_readdata,
    input  logic        coe_clr,
    output logic [15:0] coe_words_written,
    output logic        coe_err
);

    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned PEND_W = $clog2(MAX_PEND + 1);

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic              req;
    logic              rd_only;
    logic              ws_wait;
    logic              thr_wait;
    logic              accept;
    logic              wr_acc;
    logic              rd_acc;
    logic              in_range;
    logic [ADDR_W-1:0] idx;

    assign req      = avs_s1_read | avs_s1_write;
    // A read issued together with a write is treated as a write.
    assign rd_only  = avs_s1_read & ~avs_s1_write;
    assign in_range = (32'(avs_s1_address) < DEPTH);
    assign idx      = avs_s1_address[ADDR_W-1:0];

    // Gated by reset so nothing is accepted (and waitrequest reads 0) in reset.
    assign avs_s1_waitrequest = rsi_reset_n & (ws_wait | thr_wait);
    assign accept             = rsi_reset_n & req & ~(ws_wait | thr_wait);
    assign wr_acc             = accept & avs_s1_write;
    assign rd_acc             = accept & rd_only;

    // ------------------------------------------------------------------
    // Wait-state counter: stalls each request for WAIT_STATES cycles
    // ------------------------------------------------------------------
    generate
        if (WAIT_STATES == 0) begin : g_no_ws
            assign ws_wait = 1'b0;
        end else begin : g_ws
            localparam int unsigned WS_W = $clog2(WAIT_STATES + 1);

            logic [WS_W-1:0] ws_q;
            logic [WS_W-1:0] ws_d;
            logic            ws_busy;

            assign ws_busy = (ws_q < WS_W'(WAIT_STATES));
            assign ws_wait = req & ws_busy;

            // Counts up while a request is held; restarts on accept or when the
            // request is withdrawn. Holds at the limit while throttled.
            always_comb begin
                ws_d = ws_q;
                if (!req) begin
                    ws_d = '0;
                end else if (ws_busy) begin
                    ws_d = ws_q + WS_W'(1);
                end else if (accept) begin
                    ws_d = '0;
                end
            end

            always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
                if (!rsi_reset_n) begin
                    ws_q <= '0;
                end else begin
                    ws_q <= ws_d;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outstanding-read throttle
    // ------------------------------------------------------------------
    logic [PEND_W-1:0] pend_q;

    // A slot held by the read presenting data this cycle counts as free.
    assign thr_wait = rd_only &
                      ((pend_q - PEND_W'(avs_s1_readdatavalid)) == PEND_W'(MAX_PEND));

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_q + PEND_W'(rd_acc) - PEND_W'(avs_s1_readdatavalid);
        end
    end

    // ------------------------------------------------------------------
    // Word memory: contents survive reset
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge csi_clk) begin
        if (wr_acc && in_range) begin
            mem[idx] <= avs_s1_writedata;
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline: stage 0 samples memory at the accept edge, later
    // stages only delay. Data is zero unless the stage carries a valid
    // in-range read, so readdata is zero whenever readdatavalid is low.
    // ------------------------------------------------------------------
    logic [READ_LAT-1:0] vld_q;
    logic [DATA_W-1:0]   dat_q [READ_LAT];

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            vld_q <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_acc;
            dat_q[0] <= (rd_acc && in_range) ? mem[idx] : '0;
            for (int i = 1; i < READ_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign avs_s1_readdatavalid = vld_q[READ_LAT-1];
    assign avs_s1_readdata      = dat_q[READ_LAT-1];

    // ------------------------------------------------------------------
    // Status: write counter and sticky error, clear has priority
    // ------------------------------------------------------------------
    logic err_evt;

    assign err_evt = (accept & ~in_range) |
                     (accept & avs_s1_read & avs_s1_write);

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            coe_words_written <= '0;
            coe_err           <= 1'b0;
        end else if (coe_clr) begin
            coe_words_written <= '0;
            coe_err           <= 1'b0;
        end else begin
            if (wr_acc && in_range && (coe_words_written != '1)) begin
                coe_words_written <= coe_words_written + CNT_W'(1);
            end
            if (err_evt) begin
                coe_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conclover_sample_ram.sv
// Bench for conclover_sample_ram. Two instances share clock and reset:
//   dut 0: DEPTH=1024, READ_LAT=2, MAX_PEND=1, WAIT_STATES=0
//   dut 1: DEPTH=1024, READ_LAT=2, MAX_PEND=2, WAIT_STATES=3
// Expected read data and arrival cycle are queued when a read is accepted
// and checked when readdatavalid appears.

`timescale 1ns/1ps

module tb_conclover_sample_ram;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  wr;
    logic [1:0]  rd;
    logic [1:0]  clr;
    logic [1:0]  wreq;
    logic [1:0]  rdv;
    logic [1:0]  err;
    logic [15:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic [15:0] words [2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb [2][$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    conclover_sample_ram #(
        .DEPTH(1024), .READ_LAT(2), .MAX_PEND(1), .WAIT_STATES(0)
    ) dut0 (
        .csi_clk              (clk),
        .rsi_reset_n          (rst_n),
        .avs_s1_write         (wr[0]),
        .avs_s1_read          (rd[0]),
        .avs_s1_address       (addr[0]),
        .avs_s1_writedata     (wdata[0]),
        .avs_s1_waitrequest   (wreq[0]),
        .avs_s1_readdatavalid (rdv[0]),
        .avs_s1_readdata      (rdata[0]),
        .coe_clr              (clr[0]),
        .coe_words_written    (words[0]),
        .coe_err              (err[0])
    );

    conclover_sample_ram #(
        .DEPTH(1024), .READ_LAT(2), .MAX_PEND(2), .WAIT_STATES(3)
    ) dut1 (
        .csi_clk              (clk),
        .rsi_reset_n          (rst_n),
        .avs_s1_write         (wr[1]),
        .avs_s1_read          (rd[1]),
        .avs_s1_address       (addr[1]),
        .avs_s1_writedata     (wdata[1]),
        .avs_s1_waitrequest   (wreq[1]),
        .avs_s1_readdatavalid (rdv[1]),
        .avs_s1_readdata      (rdata[1]),
        .coe_clr              (clr[1]),
        .coe_words_written    (words[1]),
        .coe_err              (err[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitor: every readdatavalid must match the oldest expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            exp_t e;
            if (rdv[d] === 1'b1) begin
                if (sb[d].size() == 0) begin
                    check($sformatf("d%0d_rdv_unexpected", d), 32'd1, 32'd0);
                end else begin
                    e = sb[d].pop_front();
                    check($sformatf("d%0d_rdata", d), rdata[d], e.data);
                    check($sformatf("d%0d_rdv_cycle", d), 32'(cyc), 32'(e.cyc));
                end
            end else begin
                check((d == 0) ? "d0_rdata_idle" : "d1_rdata_idle", rdata[d], 32'd0);
            end
        end
    end

    // Holds a request until accepted; called and returns at posedge+1.
    task automatic xfer(input int d, input bit w, input bit r, input logic [15:0] a,
                        input logic [31:0] wd, input bit exp_rdv, input logic [31:0] exp_rd,
                        output int waits);
        bit   done;
        exp_t e;
        done  = 1'b0;
        waits = 0;
        wr[d] = w;
        rd[d] = r;
        addr[d]  = a;
        wdata[d] = wd;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (wreq[d] === 1'b0) begin
                done = 1'b1;
                if (exp_rdv) begin
                    e.data = exp_rd;
                    e.cyc  = cyc + 2;
                    sb[d].push_back(e);
                end
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        wr[d] = 1'b0;
        rd[d] = 1'b0;
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wr_word(input int d, input logic [15:0] a, input logic [31:0] wd,
                           input int exp_waits);
        int waits;
        xfer(d, 1'b1, 1'b0, a, wd, 1'b0, 32'd0, waits);
        check($sformatf("d%0d_wr_waits_%04h", d, a), 32'(waits), 32'(exp_waits));
    endtask

    task automatic rd_word(input int d, input logic [15:0] a, input logic [31:0] exp,
                           input int exp_waits);
        int waits;
        xfer(d, 1'b0, 1'b1, a, 32'd0, 1'b1, exp, waits);
        check($sformatf("d%0d_rd_waits_%04h", d, a), 32'(waits), 32'(exp_waits));
    endtask

    task automatic drain(input int d);
        for (int n = 0; n < 10 && sb[d].size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        check($sformatf("d%0d_drain", d), 32'(sb[d].size()), 32'd0);
    endtask

    task automatic pulse_clr(input int d);
        clr[d] = 1'b1;
        @(posedge clk);
        #1;
        clr[d] = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag, input int d);
        check({tag, "_wreq"},  32'(wreq[d]), 32'd0);
        check({tag, "_rdv"},   32'(rdv[d]),  32'd0);
        check({tag, "_rdata"}, rdata[d],     32'd0);
        check({tag, "_words"}, 32'(words[d]), 32'd0);
        check({tag, "_err"},   32'(err[d]),  32'd0);
    endtask

    // Watchdog: the run is far shorter than this.
    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waits;
        wr  = '0;
        rd  = '0;
        clr = '0;
        for (int d = 0; d < 2; d++) begin
            addr[d]  = '0;
            wdata[d] = '0;
        end

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("d0_reset", 0);
        check_zero_outputs("d1_reset", 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Zero-wait round trip
        wr_word(0, 16'h0005, 32'hDEADBEEF, 0);
        rd_word(0, 16'h0005, 32'hDEADBEEF, 0);
        drain(0);
        check("d0_words_one", 32'(words[0]), 32'd1);

        // Back-to-back writes, then read right after a write to the same word
        wr_word(0, 16'h0000, 32'hA0A0A0A0, 0);
        wr_word(0, 16'h0001, 32'hA1A1A1A1, 0);
        wr_word(0, 16'h0002, 32'hA2A2A2A2, 0);
        wr_word(0, 16'h0003, 32'h33333333, 0);
        rd_word(0, 16'h0003, 32'h33333333, 0);
        drain(0);
        check("d0_words_five", 32'(words[0]), 32'd5);

        // Throttle with MAX_PEND=1: one stall cycle after each accepted read
        rd_word(0, 16'h0000, 32'hA0A0A0A0, 0);
        rd_word(0, 16'h0001, 32'hA1A1A1A1, 1);
        rd_word(0, 16'h0002, 32'hA2A2A2A2, 1);
        drain(0);

        // Out-of-range write and read
        check("d0_err_before_range", 32'(err[0]), 32'd0);
        wr_word(0, 16'h0400, 32'hCAFEF00D, 0);
        check("d0_err_range_wr", 32'(err[0]), 32'd1);
        check("d0_words_range_wr", 32'(words[0]), 32'd5);
        rd_word(0, 16'h0400, 32'h00000000, 0);
        rd_word(0, 16'h0000, 32'hA0A0A0A0, 1);
        drain(0);
        pulse_clr(0);
        check("d0_err_cleared", 32'(err[0]), 32'd0);
        check("d0_words_cleared", 32'(words[0]), 32'd0);

        // Wait states on dut 1
        wr_word(1, 16'h0007, 32'h07070707, 3);
        rd_word(1, 16'h0007, 32'h07070707, 3);
        drain(1);
        check("d1_words_one", 32'(words[1]), 32'd1);

        // Reset during an in-flight read
        wr_word(0, 16'h0009, 32'h09090909, 0);
        wr_word(0, 16'hFFFF, 32'h12345678, 0);
        check("d0_err_pre_reset", 32'(err[0]), 32'd1);
        xfer(0, 1'b0, 1'b1, 16'h0005, 32'd0, 1'b0, 32'd0, waits);
        check("d0_inflight_waits", 32'(waits), 32'd0);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("d0_midreset", 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rd_word(0, 16'h0005, 32'hDEADBEEF, 0);
        drain(0);

        // Counter saturation
        wr[0] = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            addr[0]  = 16'(i % 1024);
            wdata[0] = 32'(i);
            @(posedge clk);
            #1;
        end
        wr[0] = 1'b0;
        check("d0_words_full", 32'(words[0]), 32'h0000FFFF);
        wr_word(0, 16'h0010, 32'h10101010, 0);
        check("d0_words_sat", 32'(words[0]), 32'h0000FFFF);

        // Read and write together: write wins, no readdatavalid, error flagged
        check("d0_err_before_both", 32'(err[0]), 32'd0);
        xfer(0, 1'b1, 1'b1, 16'h0014, 32'hBEEF0020, 1'b0, 32'd0, waits);
        check("d0_both_waits", 32'(waits), 32'd0);
        check("d0_err_both", 32'(err[0]), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        rd_word(0, 16'h0014, 32'hBEEF0020, 0);
        drain(0);

        // Clear coinciding with error and count events
        clr[0] = 1'b1;
        wr_word(0, 16'h0400, 32'h00000000, 0);
        wr_word(0, 16'h0021, 32'h21212121, 0);
        clr[0] = 1'b0;
        check("d0_err_clr_wins", 32'(err[0]), 32'd0);
        check("d0_words_clr_wins", 32'(words[0]), 32'd0);
        rd_word(0, 16'h0021, 32'h21212121, 0);
        drain(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
